// File: rtl/c499_key_loader.sv
// -----------------------------------------------------------------------------
// c499_key_loader
//   Key-delivery stage for the locked c499 SEC core. The loader receives a
//   serial frame, MSB first: 40 key bits followed by 8 CRC bits. The CRC is
//   x^8+x^2+x+1 with init 0x00 and no final XOR. The frame is accepted only
//   if the remainder over all 48 bits is zero. Only a verified frame changes
//   the registered key outputs. MAX_FAIL consecutive CRC failures put the
//   loader into LOCKOUT, which forces the key to zero until rst.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   load_start  in   1   1-cycle pulse: begin/restart frame reception
//   sin_valid   in   1   serial bit valid
//   sin_data    in   1   serial bit (frame MSB first)
//   sin_ready   out  1   a bit transfers when sin_valid & sin_ready
//   key_x       out  36  XOR key bits, key_x[i] -> X_(i+1)
//   key_p       out  4   mux key bits,  key_p[j] -> p(j+1)
//   key_loaded  out  1   a verified key is present on key_x/key_p
//   crc_err     out  1   1-cycle pulse on a frame that fails CRC
//   locked_out  out  1   sticky lockout indicator, cleared only by rst
// -----------------------------------------------------------------------------
module c499_key_loader #(
    parameter int KEY_W    = 40,
    parameter int XOR_KEYS = 36,
    parameter int MUX_KEYS = 4,
    parameter int CRC_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                sin_valid,
    input  logic                sin_data,
    output logic                sin_ready,
    output logic [XOR_KEYS-1:0] key_x,
    output logic [MUX_KEYS-1:0] key_p,
    output logic                key_loaded,
    output logic                crc_err,
    output logic                locked_out
);

    localparam int FRAME_W = KEY_W + CRC_W;
    localparam int FC_W    = $clog2(MAX_FAIL + 1);

    localparam logic [CRC_W-1:0] CRC_POLY   = CRC_W'(8'h07);
    localparam logic [5:0]       KEY_BITS   = 6'(KEY_W);
    localparam logic [5:0]       LAST_BIT   = 6'(FRAME_W - 1);
    localparam logic [FC_W-1:0]  FAIL_LIMIT = FC_W'(MAX_FAIL);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_ACTIVE  = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    logic [2:0]       state;
    logic [KEY_W-1:0] shadow;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_nxt;
    logic [5:0]       bit_cnt;
    logic [FC_W-1:0]  fail_cnt;
    logic             crc_fb;

    // Serial CRC step: feedback is the outgoing MSB XOR the incoming bit.
    // Because the CRC bits are shifted through as well, a good frame leaves
    // a zero remainder.
    always_comb begin
        crc_fb  = crc[CRC_W-1] ^ sin_data;
        crc_nxt = {crc[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    end

    // Depends on state only, so there is no combinational path from inputs.
    assign sin_ready = (state == S_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            crc        <= '0;
            bit_cnt    <= '0;
            fail_cnt   <= '0;
            key_x      <= '0;
            key_p      <= '0;
            key_loaded <= 1'b0;
            crc_err    <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge values of state, crc and bit_cnt regardless of statement order.
            crc_err <= 1'b0;

            case (state)
                S_IDLE, S_ACTIVE: begin
                    if (load_start) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                        crc     <= '0;
                        shadow  <= '0;
                    end
                end

                S_SHIFT: begin
                    if (load_start) begin
                        // Restart: discard progress and any bit offered this cycle.
                        bit_cnt <= '0;
                        crc     <= '0;
                        shadow  <= '0;
                    end else if (sin_valid) begin
                        crc     <= crc_nxt;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt < KEY_BITS) begin
                            shadow <= {shadow[KEY_W-2:0], sin_data};
                        end
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (crc == '0) begin
                        // Key outputs change only here, in one edge, so the
                        // core never sees a partial key.
                        state      <= S_ACTIVE;
                        key_x      <= shadow[KEY_W-1:MUX_KEYS];
                        key_p      <= shadow[MUX_KEYS-1:0];
                        key_loaded <= 1'b1;
                        fail_cnt   <= '0;
                    end else begin
                        state    <= S_FAIL;
                        fail_cnt <= fail_cnt + FC_W'(1);
                        crc_err  <= 1'b1;
                    end
                end

                S_FAIL: begin
                    if (fail_cnt == FAIL_LIMIT) begin
                        state      <= S_LOCKOUT;
                        key_x      <= '0;
                        key_p      <= '0;
                        key_loaded <= 1'b0;
                        locked_out <= 1'b1;
                    end else if (key_loaded) begin
                        state <= S_ACTIVE;
                    end else begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                        crc     <= '0;
                        shadow  <= '0;
                    end
                end

                S_LOCKOUT: begin
                    state <= S_LOCKOUT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c499_key_loader.sv
// -----------------------------------------------------------------------------
// tb_c499_key_loader
//   Directed self-checking bench for c499_key_loader. Frames are built as
//   {key, crc8(key)}. The tests cover reset, good and bad frames, lockout,
//   reload with stalls and a restart, and an asynchronous reset in the
//   middle of a frame.
// -----------------------------------------------------------------------------
module tb_c499_key_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        sin_valid;
    logic        sin_data;
    logic        sin_ready;
    logic [35:0] key_x;
    logic [3:0]  key_p;
    logic        key_loaded;
    logic        crc_err;
    logic        locked_out;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;

    localparam logic [39:0] KEY_A = 40'hA5_C3_96_0F_E1;
    localparam logic [39:0] KEY_B = 40'h3C_5A_F0_12_87;

    c499_key_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .sin_ready  (sin_ready),
        .key_x      (key_x),
        .key_p      (key_p),
        .key_loaded (key_loaded),
        .crc_err    (crc_err),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    // Count high crc_err cycles, sampled away from the active edge.
    always @(negedge clk) if (crc_err === 1'b1) err_pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC-8 (poly 0x07, init 0, MSB first) over the 40 key bits.
    function automatic logic [7:0] crc8(input logic [39:0] d);
        logic [7:0] c = 8'h00;
        for (int i = 39; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Pulse load_start while offering a junk bit. The bit must be dropped.
    task automatic start_pulse();
        @(negedge clk);
        load_start = 1'b1;
        sin_valid  = 1'b1;
        sin_data   = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        sin_valid  = 1'b0;
    endtask

    // Offer one bit and return just after the edge that transfers it.
    task automatic send_bit(input logic b, input bit gaps);
        int w = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                sin_valid = 1'b0;
            end
        end
        @(negedge clk);
        sin_valid = 1'b1;
        sin_data  = b;
        while (!sin_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!sin_ready) check("ready_timeout", 64'(sin_ready), 64'd1);
        else @(posedge clk);
    endtask

    // Send a whole frame. Return at the negedge of the CHECK cycle.
    task automatic send_frame(input logic [47:0] frame, input bit gaps);
        start_pulse();
        for (int i = 47; i >= 0; i--) send_bit(frame[i], gaps);
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    // Send a good frame and verify the exact 2-cycle load latency.
    task automatic load_good(input string tag, input logic [39:0] k,
                             input logic [39:0] prev_k, input bit gaps);
        send_frame({k, crc8(k)}, gaps);
        check({tag, "_hold_x"}, 64'(key_x), 64'(prev_k[39:4]));
        check({tag, "_hold_p"}, 64'(key_p), 64'(prev_k[3:0]));
        @(negedge clk);
        check({tag, "_key_x"}, 64'(key_x), 64'(k[39:4]));
        check({tag, "_key_p"}, 64'(key_p), 64'(k[3:0]));
        check({tag, "_loaded"}, 64'(key_loaded), 64'd1);
    endtask

    // Send a bad frame and verify the one-cycle crc_err pulse.
    task automatic load_bad(input string tag, input logic [39:0] k, input logic [7:0] bad_crc);
        int p0;
        send_frame({k, bad_crc}, 1'b0);
        p0 = err_pulses;
        @(negedge clk);
        check({tag, "_crc_err_hi"}, 64'(crc_err), 64'd1);
        @(negedge clk);
        check({tag, "_crc_err_lo"}, 64'(crc_err), 64'd0);
        check({tag, "_one_pulse"}, 64'(err_pulses - p0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_before;
        rst = 1'b1; load_start = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_key_x", 64'(key_x), 64'd0);
        check("rst_key_p", 64'(key_p), 64'd0);
        check("rst_loaded", 64'(key_loaded), 64'd0);
        check("rst_crc_err", 64'(crc_err), 64'd0);
        check("rst_locked", 64'(locked_out), 64'd0);
        check("rst_ready", 64'(sin_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(sin_ready), 64'd0);

        // 1. All-zero frame passes CRC
        load_good("t1", 40'h0, 40'h0, 1'b0);

        // 2. key=1, crc=0x07 (hand-computed)
        p_before = err_pulses;
        send_frame({40'h00_0000_0001, 8'h07}, 1'b0);
        @(negedge clk);
        check("t2_key_p", 64'(key_p), 64'h1);
        check("t2_key_x", 64'(key_x), 64'h0);
        check("t2_no_err", 64'(err_pulses - p_before), 64'd0);

        // 3. same key, crc=0x06 -> one error, key unchanged, back in ACTIVE
        load_bad("t3", 40'h00_0000_0001, 8'h06);
        check("t3_key_p", 64'(key_p), 64'h1);
        check("t3_key_x", 64'(key_x), 64'h0);
        check("t3_fail_cnt", 64'(dut.fail_cnt), 64'd1);
        check("t3_loaded", 64'(key_loaded), 64'd1);
        check("t3_ready", 64'(sin_ready), 64'd0);

        // 4. good key A clears fail_cnt, then three bad frames lock out
        load_good("t4a", KEY_A, 40'h00_0000_0001, 1'b0);
        check("t4_fail_clr", 64'(dut.fail_cnt), 64'd0);
        load_bad("t4b1", KEY_A, crc8(KEY_A) ^ 8'h01);
        check("t4_hold1", 64'(key_x), 64'(KEY_A[39:4]));
        check("t4_nolock1", 64'(locked_out), 64'd0);
        load_bad("t4b2", KEY_B, 8'h00);
        check("t4_hold2", 64'(key_p), 64'(KEY_A[3:0]));
        send_frame({KEY_A, crc8(KEY_A) ^ 8'h80}, 1'b0);
        @(negedge clk);
        check("t4_crc_err3", 64'(crc_err), 64'd1);
        @(negedge clk);
        check("t4_locked", 64'(locked_out), 64'd1);
        check("t4_key_x0", 64'(key_x), 64'd0);
        check("t4_key_p0", 64'(key_p), 64'd0);
        check("t4_loaded0", 64'(key_loaded), 64'd0);
        start_pulse();
        repeat (3) @(negedge clk);
        check("t4_ready_lock", 64'(sin_ready), 64'd0);
        check("t4_still_lock", 64'(locked_out), 64'd1);

        // 5. reload B with stalls and a restart at bit 20; A held until B verified
        rst = 1'b1;
        @(negedge clk);
        check("t5_unlock", 64'(locked_out), 64'd0);
        rst = 1'b0;
        load_good("t5a", KEY_A, 40'h0, 1'b0);
        start_pulse();
        for (int i = 47; i > 27; i--) send_bit(KEY_B[i - 8] ^ 1'b1, 1'b1);
        check("t5_mid_x", 64'(key_x), 64'(KEY_A[39:4]));
        check("t5_mid_loaded", 64'(key_loaded), 64'd1);
        load_good("t5b", KEY_B, KEY_A, 1'b1);

        // 6. asynchronous reset at bit 30, then a fresh frame
        start_pulse();
        for (int i = 47; i > 17; i--) send_bit(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_key_x0", 64'(key_x), 64'd0);
        check("t6_key_p0", 64'(key_p), 64'd0);
        check("t6_loaded0", 64'(key_loaded), 64'd0);
        check("t6_ready0", 64'(sin_ready), 64'd0);
        @(negedge clk);
        sin_valid = 1'b0;
        rst = 1'b0;
        load_good("t6b", KEY_A, 40'h0, 1'b0);
        check("t6_locked", 64'(locked_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
